// File: rtl/axi_rd_burst_master_pkg.sv
// axi_rd_burst_master_pkg: shared defaults and burst FSM encoding for the DDR2 AXI masters
package axi_rd_burst_master_pkg;
  localparam int DEF_ADDR_WIDTH = 27;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DATA_LEVEL = 2;
  localparam int DEF_WBURST_LEN = 8;
  localparam int DEF_RBURST_LEN = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} burst_state_e;
endpackage

// File: rtl/axi_rd_burst_master.sv
// axi_rd_burst_master: splits one user read request into AXI read bursts and streams the beats back
module axi_rd_burst_master
  import axi_rd_burst_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_LEVEL = DEF_DATA_LEVEL,
  parameter int WBURST_LEN = DEF_WBURST_LEN,
  parameter int RBURST_LEN = DEF_RBURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic                  axi_rlast,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  rd_trig,
  input  logic [7:0]            rd_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_en,
  output logic                  rd_ready,
  output logic                  rd_done
);
  if (RBURST_LEN < 1 || RBURST_LEN > 256 || WBURST_LEN < 1) begin : g_bad_param
    $error("axi_rd_burst_master: burst lengths must be 1..256");
  end
  burst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            rem_q, rem_d, beats;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_data_en_q, r_hs;
  assign beats       = (rem_q > 9'(RBURST_LEN)) ? 9'(RBURST_LEN) : rem_q;
  assign axi_arvalid = state_q == ST_AR;
  assign axi_rready  = state_q == ST_R;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = axi_arvalid ? 8'(beats - 9'd1) : 8'd0;
  assign r_hs        = axi_rvalid & axi_rready;
  // Held low during reset so the user never sees ready while the core is being cleared.
  assign rd_ready    = (state_q == ST_IDLE) & init_end & ~rst;
  assign rd_done     = state_q == ST_DONE;
  assign rd_data     = rd_data_q;
  assign rd_data_en  = rd_data_en_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: if (rd_trig & rd_ready) begin
        addr_d  = rd_addr;
        rem_d   = {1'b0, rd_len};
        state_d = (rd_len == 8'd0) ? ST_DONE : ST_AR;
      end
      ST_AR: if (axi_arready) begin
        addr_d  = addr_q + ADDR_WIDTH'(int'(beats) * DATA_LEVEL);
        state_d = ST_R;
      end
      ST_R: if (r_hs) begin
        rem_d   = rem_q - 9'd1;
        state_d = axi_rlast ? ((rem_q > 9'd1) ? ST_AR : ST_DONE) : ST_R;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      rd_data_q    <= '0;
      rd_data_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      rd_data_q    <= r_hs ? axi_rdata : rd_data_q;
      rd_data_en_q <= r_hs;
    end
  end
endmodule

// File: tb/tb_axi_rd_burst_master.sv
// tb_axi_rd_burst_master: directed checks of burst splitting, data forwarding, wrap, reset and zero-length requests
module tb_axi_rd_burst_master;
  localparam int AW = 27;
  localparam int DW = 16;
  logic          clk = 1'b0, rst = 1'b1, init_end = 1'b0;
  logic          arvalid, arready = 1'b0, rvalid = 1'b0, rready, rlast = 1'b0;
  logic [AW-1:0] araddr, rd_addr = '0;
  logic [7:0]    arlen, rd_len = '0;
  logic [DW-1:0] rdata = '0, rd_data;
  logic          rd_trig = 1'b0, rd_data_en, rd_ready, rd_done;
  int errs = 0, checks = 0;
  int ar_delay = 0, rv_gap = 0;
  logic [AW-1:0] ar_addr_q[$];
  logic [7:0]    ar_len_q[$];
  logic [DW-1:0] got[$];
  logic [15:0]   sdat = '0;
  int left = 0, wcnt = 0, gapc = 0, done_cnt = 0, arv_cnt = 0, stab_err = 0, lag_err = 0;
  bit inb = 1'b0, p_arv = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [7:0]    p_len = '0;
  int ab, gb, dc, arv0;
  logic [15:0] db;
  always #5 clk = ~clk;
  axi_rd_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_LEVEL(2), .WBURST_LEN(8), .RBURST_LEN(8)) dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arlen(arlen),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rlast(rlast), .axi_rdata(rdata),
    .rd_trig(rd_trig), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_en(rd_data_en), .rd_ready(rd_ready), .rd_done(rd_done)
  );
  // Slave model and monitor, acting on the falling edge so the DUT sees stable inputs.
  always @(negedge clk) begin
    if (rst) begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; inb = 1'b0; wcnt = 0; gapc = 0; p_arv = 1'b0;
    end else begin
      if (rd_data_en !== rvalid) lag_err++;
      if (rd_data_en) got.push_back(rd_data);
      if (rd_done) done_cnt++;
      if (arvalid) arv_cnt++;
      if (arvalid && p_arv && (araddr !== p_addr || arlen !== p_len)) stab_err++;
      p_arv = arvalid; p_addr = araddr; p_len = arlen;
      if (rvalid) begin
        left--;
        if (rlast) inb = 1'b0;
      end
      rvalid = 1'b0; rlast = 1'b0;
      if (arready) begin
        arready = 1'b0; inb = 1'b1; left = int'(ar_len_q[$]) + 1; gapc = 0;
      end else if (arvalid && !inb) begin
        if (wcnt >= ar_delay) begin
          arready = 1'b1; wcnt = 0;
          ar_addr_q.push_back(araddr); ar_len_q.push_back(arlen);
        end else wcnt++;
      end
      if (inb && left > 0) begin
        if (gapc > 0) gapc--;
        else begin
          rvalid = 1'b1; rdata = 16'h1000 + sdat; sdat++; rlast = (left == 1); gapc = rv_gap;
        end
      end
    end
  end
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    ab = ar_addr_q.size(); gb = got.size(); db = sdat; dc = done_cnt; arv0 = arv_cnt;
  endtask
  task automatic req(logic [AW-1:0] a, logic [7:0] n);
    int t = 0;
    while (rd_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    chk("req_ready", rd_ready, 1);
    rd_trig = 1'b1; rd_addr = a; rd_len = n;
    @(negedge clk);
    rd_trig = 1'b0;
  endtask
  task automatic wait_done(string tag);
    int t = 0;
    while (rd_done !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    chk({tag, "_done_seen"}, rd_done, 1);
    @(negedge clk);
    chk({tag, "_ready_after"}, rd_ready, 1);
    chk({tag, "_done_pulse"}, rd_done, 0);
    chk({tag, "_done_count"}, done_cnt - dc, 1);
  endtask
  task automatic chk_ar(string tag, int i, logic [AW-1:0] a, logic [7:0] l);
    chk($sformatf("%s_araddr%0d", tag, i), ar_addr_q[ab+i], a);
    chk($sformatf("%s_arlen%0d", tag, i), ar_len_q[ab+i], l);
  endtask
  task automatic chk_data(string tag, int n);
    chk({tag, "_beats"}, got.size() - gb, n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_data%0d", tag, i), got[gb+i], 16'(16'h1000 + db + 16'(i)));
  endtask
  initial begin
    init_end = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_data_en", rd_data_en, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_done", rd_done, 0);
    chk("rst_ready", rd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", rd_ready, 1);
    snap(); req('0, 8'd48); wait_done("t1");
    chk("t1_bursts", ar_addr_q.size() - ab, 6);
    for (int i = 0; i < 6; i++) chk_ar("t1", i, AW'(16 * i), 8'd7);
    chk_data("t1", 48);
    snap(); req('0, 8'd20); wait_done("t2");
    chk("t2_bursts", ar_addr_q.size() - ab, 3);
    chk_ar("t2", 0, 'd0, 8'd7);
    chk_ar("t2", 1, 'd16, 8'd7);
    chk_ar("t2", 2, 'd32, 8'd3);
    chk_data("t2", 20);
    ar_delay = 5; rv_gap = 1;
    snap(); req('h100, 8'd10); wait_done("t3");
    chk("t3_bursts", ar_addr_q.size() - ab, 2);
    chk_ar("t3", 0, 'h100, 8'd7);
    chk_ar("t3", 1, 'h110, 8'd1);
    chk("t3_arvalid_cycles", arv_cnt - arv0, 12);
    chk("t3_ar_stable", stab_err, 0);
    chk("t3_data_lag", lag_err, 0);
    chk_data("t3", 10);
    ar_delay = 0; rv_gap = 0;
    init_end = 1'b0;
    snap();
    rd_trig = 1'b1; rd_addr = 'h200; rd_len = 8'd8;
    repeat (3) @(negedge clk);
    chk("t4_ready_low", rd_ready, 0);
    chk("t4_no_ar", arv_cnt - arv0, 0);
    init_end = 1'b1;
    @(negedge clk);
    rd_trig = 1'b0;
    chk("t4_arvalid", arvalid, 1);
    chk("t4_araddr", araddr, 'h200);
    wait_done("t4");
    chk("t4_bursts", ar_addr_q.size() - ab, 1);
    chk_ar("t4", 0, 'h200, 8'd7);
    chk_data("t4", 8);
    snap(); req(27'h7FFFFF0, 8'd16); wait_done("t5");
    chk("t5_bursts", ar_addr_q.size() - ab, 2);
    chk_ar("t5", 0, 27'h7FFFFF0, 8'd7);
    chk_ar("t5", 1, 'd0, 8'd7);
    chk_data("t5", 16);
    snap(); req('h40, 8'd16);
    begin
      int t = 0;
      while (!(ar_addr_q.size() - ab == 2 && rready === 1'b1 && got.size() - gb >= 10) && t < 500) begin
        @(negedge clk); t++;
      end
      chk("t6_reached_burst2", t < 500, 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_arvalid", arvalid, 0);
    chk("t6_rready", rready, 0);
    chk("t6_araddr", araddr, 0);
    chk("t6_data_en", rd_data_en, 0);
    chk("t6_data", rd_data, 0);
    chk("t6_done", rd_done, 0);
    chk("t6_ready", rd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt - dc, 0);
    snap(); req('0, 8'd8); wait_done("t6b");
    chk("t6b_bursts", ar_addr_q.size() - ab, 1);
    chk_ar("t6b", 0, 'd0, 8'd7);
    chk_data("t6b", 8);
    snap(); req('h300, 8'd0);
    chk("t7_done_next", rd_done, 1);
    wait_done("t7");
    chk("t7_no_arvalid", arv_cnt - arv0, 0);
    chk("t7_bursts", ar_addr_q.size() - ab, 0);
    chk("t7_beats", got.size() - gb, 0);
    chk("all_ar_stable", stab_err, 0);
    chk("all_data_lag", lag_err, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/axi_rd_burst_master.md
Name: axi_rd_burst_master

Overview:
- User-side read front end for the DDR2 controller's AXI read channel.
- Accepts one read request (start address, beat count), splits it into AXI read bursts of RBURST_LEN beats, and issues them on AR.
- Forwards returned R beats to the user, then pulses done.
- Sits between user logic and ddr2_ctrl in the core clock domain.

Parameters:
- ADDR_WIDTH, 27: byte address width (row+col+bank).
- DATA_WIDTH, 16: beat width in bits.
- DATA_LEVEL, 2: address units per beat; next beat address = +DATA_LEVEL.
- WBURST_LEN, 8: carried for parameter uniformity with the write master; no effect here.
- RBURST_LEN, 8: maximum beats per AXI read burst (1..256).

Ports:
- clk  in  1  core clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_end  in  1  DDR2 initialisation complete; gates request acceptance.
- axi_arvalid  out  1  AR valid.
- axi_arready  in  1  AR ready.
- axi_araddr  out  ADDR_WIDTH  burst start address.
- axi_arlen  out  8  beats-1 of burst.
- axi_rvalid  in  1  R valid.
- axi_rready  out  1  R ready.
- axi_rlast  in  1  last beat of burst.
- axi_rdata  in  DATA_WIDTH  read data.
- rd_trig  in  1  request strobe, held by user until accepted.
- rd_len  in  8  total beats requested.
- rd_addr  in  ADDR_WIDTH  request start address.
- rd_data  out  DATA_WIDTH  returned beat.
- rd_data_en  out  1  rd_data valid, one cycle per beat.
- rd_ready  out  1  master idle and able to accept.
- rd_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; internal counters 0.
- rd_ready = 1 only in IDLE with init_end = 1.
- Acceptance: on a cycle with rd_trig & rd_ready, rd_addr and rd_len are captured and the FSM goes to AR.
- rd_len = 0 is accepted: no AXI traffic; rd_done pulses on the next cycle.
- State machine:
  - IDLE.
  - AR: axi_arvalid = 1 with stable araddr/arlen until arready. On the handshake, go to R.
  - R: axi_rready = 1. Each rvalid & rready beat decrements the remaining count. On the rlast beat: if remaining > 0, go to AR; else go to DONE.
  - DONE: rd_done = 1 for one cycle, then IDLE.
- Burst sizing: beats = min(remaining, RBURST_LEN); axi_arlen = beats-1. The final partial burst uses the residue.
- Burst address: first burst = captured rd_addr. Each following burst = previous + beats*DATA_LEVEL, modulo 2^ADDR_WIDTH (wraps).
- Remaining-count width: 9 bits.
- Data path: rd_data and rd_data_en are registered. rd_data_en = 1 exactly one cycle after each accepted R beat; rd_data = that beat's axi_rdata. Beat order is preserved; no gaps are added beyond those on rvalid.
- Burst termination is by rlast. Beat/rlast mismatch is not detected.
- init_end deasserting mid-request does not abort the request; it only blocks new acceptance.
- rd_trig asserted while busy is ignored (rd_ready = 0).
- rst mid-operation: immediate return to IDLE, outputs cleared, in-flight request discarded.
- AR for the next burst is issued only after the previous rlast (one outstanding burst).

Decomposition:
- Shared package: ADDR_WIDTH, DATA_WIDTH, DATA_LEVEL, WBURST_LEN, RBURST_LEN defaults and the FSM state encoding, shared with the write master.
- No sub-module needed. Optionally one burst_splitter (remaining/address/arlen computation) reusable by the write master.

Test Plan:
- rd_addr=0, rd_len=48, RBURST_LEN=8, slave ready always -> 6 AR at 0,16,32,48,64,80, arlen=7 each; 48 rd_data_en pulses in order; single rd_done; rd_ready back to 1 the cycle after.
- rd_len=20 -> bursts arlen 7,7,3 at addresses 0,16,32; 20 data beats; rd_done once.
- arready delayed 5 cycles, rvalid toggling every other cycle -> arvalid/araddr/arlen stable while waiting; rd_data_en follows each rvalid beat by exactly one cycle; data sequence intact.
- init_end=0 with rd_trig=1 -> rd_ready=0, no AR. Raise init_end -> accepted on the next edge.
- rd_addr=2^27-16, rd_len=16 -> second burst araddr=0 (wrap).
- rst pulsed during R of the second burst -> all outputs 0 immediately; no rd_done. A new request after reset completes normally.
- rd_len=0 -> no arvalid; rd_done pulses one cycle after acceptance.
